whirlpool_digest_serializer: RTL
================================

WHIRLPOOL_DIGEST_SERIALIZER -- requirements
Module: whirlpool_digest_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 64, output word width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  512-bit state vector on in_data is valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a vector this cycle.
REQ-006 SHALL have port in_data  input  [0:511]  Whirlpool state vector, row-major; bits [0:7] = byte B00, bits [504:511] = byte B77.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the word this cycle.
REQ-009 SHALL have port out_data  output  [WORD_W-1:0]  current serialized word.
REQ-010 SHALL have port out_last  output  1  out_data is the final word of the vector.
REQ-011 SHALL have port busy  output  1  a vector is held and not fully drained.

Function
REQ-012 SHALL define NWORDS = 512/WORD_W and a word index counter of width clog2(NWORDS), minimum 1 bit.
REQ-013 SHALL implement states IDLE and DRAIN; IDLE -> DRAIN on input handshake; DRAIN -> IDLE on output handshake of the last word unless a new vector is accepted in the same cycle.
REQ-014 SHALL drive in_ready = 1 in IDLE, and in DRAIN only when out_valid & out_ready & out_last (back-to-back acceptance, no bubble).
REQ-015 SHALL capture in_data into a 512-bit holding register on in_valid & in_ready; in_data ignored otherwise.
REQ-016 SHALL assert out_valid the cycle after acceptance (latency 1) and keep it asserted through all NWORDS words with no gaps while out_ready is high.
REQ-017 SHALL emit word k = held[k*WORD_W : k*WORD_W+WORD_W-1], k = 0..NWORDS-1, with held bit k*WORD_W mapped to out_data MSB.
REQ-018 SHALL hold out_data, out_last and out_valid stable while out_valid & !out_ready.
REQ-019 SHALL advance the word index only on out_valid & out_ready; index wraps to 0 after NWORDS-1.
REQ-020 SHALL assert out_last exactly when out_valid and index == NWORDS-1.
REQ-021 SHALL drive busy = 1 in DRAIN, 0 in IDLE.
REQ-022 SHALL, on simultaneous last-word handshake and new input handshake, present word 0 of the new vector in the next cycle with out_valid held high.

Reset
REQ-023 SHALL on rst: state IDLE, index 0, out_valid 0, out_last 0, busy 0, in_ready 1 after reset release, holding register and out_data 0.
REQ-024 SHALL discard any partially drained vector when rst asserts mid-operation; no further words emitted.
REQ-025 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-026 SHALL support macro WHIRLPOOL_SER_BYTESWAP_EN: when defined, byte j of each word (j=0 most significant) is output at byte position WORD_W/8-1-j; when undefined, bytes pass in natural order of REQ-017.
REQ-027 SHALL keep timing, handshake and out_last behaviour identical with and without the macro.

Structure
REQ-028 SHALL take WHIRLPOOL_STATE_W (512), WHIRLPOOL_BYTE_W (8) and the state-vector typedef from shared package whirlpool_pkg.
REQ-029 SHALL be a single module; no sub-module is required (state register, counter and word mux are inline).

Verification
REQ-030 SHALL test basic drain: WORD_W=64, in_data bytes 0x00..0x3F, out_ready=1 -> 8 consecutive words 0x0001020304050607 .. 0x38393A3B3C3D3E3F, out_last on 8th only, out_valid first seen 1 cycle after acceptance.
REQ-031 SHALL test backpressure: out_ready low for 3 cycles at word 2 -> out_data stays 0x1011121314151617, no word lost or duplicated.
REQ-032 SHALL test back-to-back: second vector (bytes 0x40..0x7F) with in_valid held -> accepted in the last-word cycle, word 0x4041424344454647 follows 0x38393A3B3C3D3E3F with no bubble.
REQ-033 SHALL test reset mid-drain: rst during word 3 -> next cycle out_valid=0, busy=0, in_ready=1; next vector restarts at word 0.
REQ-034 SHALL test WHIRLPOOL_SER_BYTESWAP_EN defined: bytes 0x00..0x3F -> first word 0x0706050403020100, last word 0x3F3E3D3C3B3A3938.
REQ-035 SHALL test WORD_W=8 -> 64 words 0x00..0x3F, out_last on 0x3F.

Source files
------------

// File: rtl/whirlpool_pkg.sv
// Shared Whirlpool constants and the 512-bit state-vector type.
// The serializer's optional WHIRLPOOL_SER_BYTESWAP_EN build flag lives in its own file.
package whirlpool_pkg;

    localparam int WHIRLPOOL_STATE_W = 512;
    localparam int WHIRLPOOL_BYTE_W  = 8;

    // Row-major state: bits [0:7] are byte B00, bits [504:511] are byte B77.
    typedef logic [0:WHIRLPOOL_STATE_W-1] whirlpool_state_t;

    function automatic int ser_idx_w(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/whirlpool_digest_serializer.sv
// Serializes a 512-bit Whirlpool state into NWORDS words of WORD_W bits, MSB-first.
// Define WHIRLPOOL_SER_BYTESWAP_EN to reverse the byte order inside each output word.
//
// state | meaning
// IDLE  | no vector held, ready for a new one
// DRAIN | vector held, emitting words 0..NWORDS-1
module whirlpool_digest_serializer
    import whirlpool_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:511]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int NWORDS = WHIRLPOOL_STATE_W / WORD_W;
    localparam int IDX_W  = ser_idx_w(NWORDS);
    localparam int NBYTES = WORD_W / WHIRLPOOL_BYTE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  idx;
    whirlpool_state_t  held;
    logic [WORD_W-1:0] word_nat;
    logic              in_hs;
    logic              out_hs;

    assign out_valid = (state == DRAIN);
    assign busy      = (state == DRAIN);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign out_hs    = out_valid && out_ready;
    // Accepting on the last-word handshake lets the next vector follow with no bubble.
    assign in_ready  = (state == IDLE) || (out_hs && out_last);
    assign in_hs     = in_valid && in_ready;

    always_comb begin
        word_nat = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (idx == k[IDX_W-1:0]) begin
                word_nat = held[k*WORD_W +: WORD_W];
            end
        end
    end

`ifdef WHIRLPOOL_SER_BYTESWAP_EN
    always_comb begin
        out_data = '0;
        for (int j = 0; j < NBYTES; j++) begin
            out_data[j*WHIRLPOOL_BYTE_W +: WHIRLPOOL_BYTE_W] =
                word_nat[(NBYTES-1-j)*WHIRLPOOL_BYTE_W +: WHIRLPOOL_BYTE_W];
        end
    end
`else
    assign out_data = word_nat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            held  <= '0;
        end else begin
            if (in_hs) begin
                held <= in_data;
            end
            if (out_hs) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_hs && out_last && !in_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
